// File: rtl/key_debounce_pkg.sv
// Shared constants and types for the six-track button debouncer and its consumers.
package key_debounce_pkg;

    localparam int unsigned N_TRACK        = 6;
    localparam int unsigned STABLE_CNT_DEF = 4;
    localparam int unsigned CNT_W_DEF      = 4;

    typedef logic [N_TRACK-1:0] track_vec_t;

endpackage

// File: rtl/key_debounce_6trk_debounce_cell.sv
// Single-track debouncer: 2-FF input synchronizer, stability counter advanced on
// tick, debounced level register and one-cycle press/release pulses.
// Ports:
//   clk, reset (async active-low) - clock and reset
//   tick                          - sample enable, one cycle per timebase edge
//   key_raw                       - raw asynchronous button input
//   key_level                     - debounced level
//   key_press / key_release       - one-cycle pulses on debounced 0->1 / 1->0
module debounce_cell
    import key_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT = STABLE_CNT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic             k1;
    logic             ks;
    logic [CNT_W-1:0] cnt;

    // Key synchronizer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k1 <= 1'b0;
            ks <= 1'b0;
        end else begin
            k1 <= key_raw;
            ks <= k1;
        end
    end

    // Stability counter, level and pulses; everything holds between ticks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (tick) begin
                if (ks == key_level) begin
                    cnt <= '0;
                end else if (cnt >= CNT_LAST) begin
                    // >= keeps the counter from ever wrapping
                    key_level   <= ks;
                    cnt         <= '0;
                    key_press   <= ks;
                    key_release <= ~ks;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/key_debounce_6trk.sv
// Six-track button debouncer. The slow clk_2ms timebase is sampled as data,
// synchronized and edge-detected into a one-cycle tick that drives one
// debounce_cell per track.
// Ports:
//   clk, reset (async active-low) - system clock and reset
//   clk_2ms                       - toggling timebase, both edges produce a tick
//   key_raw[N_TRACK]              - raw buttons, active-high
//   tick                          - one-cycle strobe per clk_2ms edge
//   key_level[N_TRACK]            - debounced levels
//   key_press / key_release       - one-cycle per-track edge pulses
module key_debounce_6trk
    import key_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT = STABLE_CNT_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_2ms,
    input  logic [N_TRACK-1:0] key_raw,
    output logic               tick,
    output logic [N_TRACK-1:0] key_level,
    output logic [N_TRACK-1:0] key_press,
    output logic [N_TRACK-1:0] key_release
);

    logic tb_sync1;
    logic tb_sync2;
    logic tb_prev;

    // Timebase synchronizer and both-edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tb_sync1 <= 1'b0;
            tb_sync2 <= 1'b0;
            tb_prev  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            tb_sync1 <= clk_2ms;
            tb_sync2 <= tb_sync1;
            tb_prev  <= tb_sync2;
            tick     <= tb_sync2 ^ tb_prev;
        end
    end

    // One independent debouncer per track
    for (genvar i = 0; i < N_TRACK; i++) begin : g_track
        debounce_cell #(
            .STABLE_CNT (STABLE_CNT),
            .CNT_W      (CNT_W)
        ) u_cell (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .key_raw     (key_raw[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debounce_6trk.sv
// Scoreboard bench for key_debounce_6trk: stimulus feeds a sample-window
// reference model that queues expected pulse events; a negedge monitor pops
// and compares whenever the DUT pulses.
module tb_key_debounce_6trk;

    localparam int unsigned NT = 6;
    localparam int unsigned SC = 4;

    typedef struct {
        int          tick_no;
        logic [NT-1:0] press;
        logic [NT-1:0] rel;
        logic [NT-1:0] level;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_2ms;
    logic [NT-1:0] key_raw;
    logic          tick;
    logic [NT-1:0] key_level;
    logic [NT-1:0] key_press;
    logic [NT-1:0] key_release;

    always #5 clk = ~clk;

    key_debounce_6trk #(.STABLE_CNT(SC), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_2ms     (clk_2ms),
        .key_raw     (key_raw),
        .tick        (tick),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release)
    );

    int            vectors     = 0;
    int            miscompares = 0;
    int            cyc         = 0;
    int            toggle_cyc  = 0;
    int            tick_idx    = 0;
    int            slot_idx    = 0;
    logic          prev_tick   = 1'b0;
    logic [NT-1:0] last_level  = '0;
    exp_t          sb[$];

    // Reference model: level flips once the last SC samples since the previous
    // flip all disagree with it
    logic [NT-1:0] m_stable;
    logic [SC-1:0] m_hist [NT];
    int            m_since[NT];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        m_stable = '0;
        for (int t = 0; t < NT; t++) begin
            m_hist[t]  = '0;
            m_since[t] = 0;
        end
    endtask

    task automatic model_step(input logic [NT-1:0] raw);
        exp_t e;
        e.press = '0;
        e.rel   = '0;
        for (int t = 0; t < NT; t++) begin
            m_hist[t] = {m_hist[t][SC-2:0], raw[t]};
            m_since[t]++;
            if (m_since[t] >= SC && m_hist[t] == {SC{~m_stable[t]}}) begin
                m_stable[t] = ~m_stable[t];
                m_since[t]  = 0;
                if (m_stable[t]) e.press[t] = 1'b1;
                else             e.rel[t]   = 1'b1;
            end
        end
        if ((e.press | e.rel) != '0) begin
            e.tick_no = slot_idx;
            e.level   = m_stable;
            sb.push_back(e);
        end
    endtask

    // One timebase half-period: toggle clk_2ms together with a new key sample
    task automatic do_slot(input logic [NT-1:0] raw);
        @(posedge clk);
        #1;
        clk_2ms    = ~clk_2ms;
        key_raw    = raw;
        toggle_cyc = cyc;
        slot_idx++;
        model_step(raw);
        repeat (9) @(posedge clk);
    endtask

    // Monitor: tick timing, pulse scoreboard, exclusivity and level deltas
    always @(negedge clk) begin
        exp_t          e;
        logic [NT-1:0] pulses;
        if (!reset) begin
            prev_tick  = 1'b0;
            last_level = '0;
        end else begin
            pulses = key_press | key_release;
            if (tick) begin
                tick_idx++;
                check("tick_latency", 32'(cyc - toggle_cyc), 32'd3);
                check("tick_width", 32'(prev_tick), 32'd0);
            end
            if (pulses != '0) begin
                check("pulse_exclusive", 32'(key_press & key_release), 32'd0);
                check("pulse_after_tick", 32'(prev_tick), 32'd1);
                if (sb.size() == 0) begin
                    check("pulse_unexpected", 32'(pulses), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("pulse_tick_no", 32'(tick_idx), 32'(e.tick_no));
                    check("press_mask", 32'(key_press), 32'(e.press));
                    check("release_mask", 32'(key_release), 32'(e.rel));
                    check("level_after_pulse", 32'(key_level), 32'(e.level));
                end
            end
            if (pulses != '0 || key_level != last_level)
                check("level_delta", 32'(key_level ^ last_level), 32'(pulses));
            prev_tick  = tick;
            last_level = key_level;
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tick"}, 32'(tick), 32'd0);
        check({tag, "_level"}, 32'(key_level), 32'd0);
        check({tag, "_press"}, 32'(key_press), 32'd0);
        check({tag, "_release"}, 32'(key_release), 32'd0);
    endtask

    task automatic do_reset_pulse();
        if (clk_2ms) do_slot(key_raw);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        model_clear();
        sb.delete();
        tick_idx = 0;
        slot_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NT-1:0] r;
        reset   = 1'b0;
        clk_2ms = 1'b0;
        key_raw = '0;
        model_clear();
        #23;
        check_outputs_zero("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Timebase: 6 toggles -> 6 ticks; constant timebase -> none
        repeat (6) do_slot('0);
        check("six_ticks", 32'(tick_idx), 32'd6);
        repeat (100) @(posedge clk);
        check("no_ticks_when_constant", 32'(tick_idx), 32'd6);

        // Clean press and release on track 0
        repeat (3) do_slot(6'b000001);
        check("press_not_yet", 32'(key_level), 32'd0);
        do_slot(6'b000001);
        check("clean_press_level", 32'(key_level), 32'h01);
        repeat (4) do_slot(6'b000000);
        check("clean_release_level", 32'(key_level), 32'h00);

        // Bounce on track 2 never reaches SC consecutive samples
        do_slot(6'b000100); do_slot(6'b000100); do_slot(6'b000100);
        do_slot(6'b000000);
        do_slot(6'b000100); do_slot(6'b000100);
        do_slot(6'b000000); do_slot(6'b000000);
        check("bounce_level", 32'(key_level), 32'h00);

        // Simultaneous press on tracks 0 and 5
        repeat (4) do_slot(6'b100001);
        check("simultaneous_level", 32'(key_level), 32'h21);

        // Reset mid-count on track 3 discards progress
        repeat (2) do_slot(6'b001000);
        do_reset_pulse();
        repeat (3) do_slot(6'b001000);
        check("post_reset_not_yet", 32'(key_level), 32'h00);
        do_slot(6'b001000);
        check("post_reset_press", 32'(key_level), 32'h08);

        // Randomized toggling on all tracks
        r = 6'b001000;
        repeat (2000) begin
            for (int t = 0; t < NT; t++)
                if ($urandom_range(0, 3) == 0) r[t] = ~r[t];
            do_slot(r);
        end
        repeat (10) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("tick_count_total", 32'(tick_idx), 32'(slot_idx));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
